// File: rtl/wb_merge_64_if.sv
// wb_merge_64_if: bundles the ALU result, load response and register-file
// write signals of the writeback merge stage.
// Handshake: a load response moves when ld_valid && ld_ready on a rising edge;
// ld_ready depends only on stage state. ALU results have no backpressure;
// the issue stage keeps alu_valid low while wb_stall is high.
interface wb_merge_64_if #(
    parameter int LD_DEPTH = 2
);
    localparam int CW = $clog2(LD_DEPTH + 1);

    logic          alu_valid;
    logic [4:0]    alu_rd;
    logic [63:0]   alu_data;
    logic          ld_valid;
    logic          ld_ready;
    logic [4:0]    ld_rd;
    logic [2:0]    ld_funct3;
    logic [63:0]   ld_data;
    logic          wb_stall;
    logic [CW-1:0] ld_count;
    logic          reg_write;
    logic [4:0]    w_reg;
    logic [63:0]   w_data;

    // Producer side: issue stage, ALU, load unit and register-file observer.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_funct3, ld_data,
        input  ld_ready, wb_stall, ld_count,
        input  reg_write, w_reg, w_data
    );

    // Merge stage side.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_funct3, ld_data,
        output ld_ready, wb_stall, ld_count,
        output reg_write, w_reg, w_data
    );
endinterface

// File: rtl/wb_merge_64.sv
// wb_merge_64: writeback merge stage in front of the 64-bit register file.
// ALU results win the single registered write port; load responses queue in
// a small FIFO and drain when the ALU is idle. A load waiting too long at the
// FIFO head raises wb_stall toward the issue stage.
// Optional feature macro: WB_LOAD_EXT_EN -- when defined, loads are sign/zero
// extended by ld_funct3 at push time; otherwise ld_data is stored as is.
module wb_merge_64 #(
    parameter int LD_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    wb_merge_64_if.slave  bus
);
    localparam int PW = $clog2(LD_DEPTH);
    localparam int CW = $clog2(LD_DEPTH + 1);
    localparam int AW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    fifo_rd_q   [LD_DEPTH];
    logic [63:0]   fifo_data_q [LD_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] age_q, age_d;
    logic          reg_write_q, reg_write_d;
    logic [4:0]    w_reg_q, w_reg_d;
    logic [63:0]   w_data_q, w_data_d;

    logic          fifo_empty;
    logic          ld_ready;
    logic          push;
    logic          pop;
    logic [63:0]   push_data;
    logic          sel_valid;
    logic [4:0]    sel_rd;
    logic [63:0]   sel_data;

    assign fifo_empty = (count_q == '0);
    assign ld_ready   = (count_q != CW'(LD_DEPTH));
    assign push       = bus.ld_valid && ld_ready;
    // The head is only visible once registered, so a fresh push into an
    // empty FIFO is never bypassed to the write port.
    assign pop        = !bus.alu_valid && !fifo_empty;

`ifdef WB_LOAD_EXT_EN
    function automatic logic [63:0] load_extend(input logic [2:0] f3,
                                                input logic [63:0] d);
        case (f3)
            3'b000:  return {{56{d[7]}}, d[7:0]};
            3'b001:  return {{48{d[15]}}, d[15:0]};
            3'b010:  return {{32{d[31]}}, d[31:0]};
            3'b100:  return {56'd0, d[7:0]};
            3'b101:  return {48'd0, d[15:0]};
            3'b110:  return {32'd0, d[31:0]};
            default: return d;  // LD and the reserved encoding
        endcase
    endfunction

    assign push_data = load_extend(bus.ld_funct3, bus.ld_data);
`else
    logic unused_funct3;

    assign push_data     = bus.ld_data;
    assign unused_funct3 = ^bus.ld_funct3;
`endif

    // Load FIFO storage; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= bus.ld_rd;
            fifo_data_q[wr_ptr_q] <= push_data;
        end
    end

    // Next-state for pointers, occupancy and head-of-line age.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        age_d    = age_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (fifo_empty || pop) begin
            age_d = '0;
        end else if (age_q != AW'(STARVE_LIMIT)) begin
            age_d = age_q + 1'b1;
        end
    end

    // Write-port select: ALU first, then the FIFO head; x0 writes are dropped.
    always_comb begin
        sel_valid   = 1'b0;
        sel_rd      = '0;
        sel_data    = '0;
        reg_write_d = 1'b0;
        w_reg_d     = w_reg_q;
        w_data_d    = w_data_q;
        if (bus.alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = bus.alu_rd;
            sel_data  = bus.alu_data;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_rd    = fifo_rd_q[rd_ptr_q];
            sel_data  = fifo_data_q[rd_ptr_q];
        end
        if (sel_valid && (sel_rd != 5'd0)) begin
            reg_write_d = 1'b1;
            w_reg_d     = sel_rd;
            w_data_d    = sel_data;
        end
    end

    // Stage state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            age_q       <= '0;
            reg_write_q <= 1'b0;
            w_reg_q     <= '0;
            w_data_q    <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            age_q       <= age_d;
            reg_write_q <= reg_write_d;
            w_reg_q     <= w_reg_d;
            w_data_q    <= w_data_d;
        end
    end

    assign bus.ld_ready  = ld_ready;
    assign bus.ld_count  = count_q;
    assign bus.wb_stall  = (age_q >= AW'(STARVE_LIMIT));
    assign bus.reg_write = reg_write_q;
    assign bus.w_reg     = w_reg_q;
    assign bus.w_data    = w_data_q;

`ifndef SYNTHESIS
    // The issue stage must hold alu_valid low while a stall is requested.
    a_no_alu_during_stall: assert property (
        @(posedge clk) disable iff (!reset_n) !(bus.alu_valid && bus.wb_stall));
`endif
endmodule

// File: tb/tb_wb_merge_64.sv
// tb_wb_merge_64: directed bench for wb_merge_64 (LD_DEPTH=2, STARVE_LIMIT=4).
// Inputs change on the falling edge; outputs are checked on the falling edge
// after the rising edge they respond to.
module tb_wb_merge_64;
    logic clk;
    logic reset_n;
    int   vectors = 0;
    int   errs    = 0;

    wb_merge_64_if #(.LD_DEPTH(2)) bus ();

    wb_merge_64 #(.LD_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    // Write monitor for the pointer-wrap stream
    logic        mon_en = 1'b0;
    logic [4:0]  got_rd_q   [$];
    logic [63:0] got_data_q [$];
    always @(negedge clk) begin
        if (mon_en && bus.reg_write && bus.w_reg != 5'd31) begin
            got_rd_q.push_back(bus.w_reg);
            got_data_q.push_back(bus.w_data);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_rd     = '0;
        bus.ld_funct3 = '0;
        bus.ld_data   = '0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [63:0] d);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = rd;
        bus.alu_data  = d;
    endtask

    task automatic drive_ld(input logic [4:0] rd, input logic [2:0] f3, input logic [63:0] d);
        bus.ld_valid  = 1'b1;
        bus.ld_rd     = rd;
        bus.ld_funct3 = f3;
        bus.ld_data   = d;
    endtask

    // One isolated load: push edge, then pop edge.
    task automatic load_one(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                            input logic [63:0] d, input logic [63:0] exp);
        idle();
        drive_ld(rd, f3, d);
        cyc();
        chk({tag, "_push_wr"}, 64'(bus.reg_write), 64'd0);
        chk({tag, "_push_cnt"}, 64'(bus.ld_count), 64'd1);
        idle();
        cyc();
        chk({tag, "_wr"}, 64'(bus.reg_write), 64'd1);
        chk({tag, "_reg"}, 64'(bus.w_reg), 64'(rd));
        chk({tag, "_data"}, bus.w_data, exp);
        chk({tag, "_cnt"}, 64'(bus.ld_count), 64'd0);
    endtask

    initial begin
        int sent;
        int budget;
        logic hs;

        // Reset, then traffic, then reset again mid-stream
        reset_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        drive_alu(5'd3, 64'hAA);
        drive_ld(5'd4, 3'b011, 64'h55);
        cyc();
        chk("pre_wr", 64'(bus.reg_write), 64'd1);
        chk("pre_cnt", 64'(bus.ld_count), 64'd1);
        idle();
        reset_n = 1'b0;
        #1;
        chk("rst_reg_write", 64'(bus.reg_write), 64'd0);
        chk("rst_w_reg", 64'(bus.w_reg), 64'd0);
        chk("rst_w_data", bus.w_data, 64'd0);
        chk("rst_ld_count", 64'(bus.ld_count), 64'd0);
        chk("rst_wb_stall", 64'(bus.wb_stall), 64'd0);
        chk("rst_ld_ready", 64'(bus.ld_ready), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // ALU write, then an x0 write that must be dropped
        drive_alu(5'd5, 64'h1234);
        cyc();
        chk("alu_wr", 64'(bus.reg_write), 64'd1);
        chk("alu_reg", 64'(bus.w_reg), 64'd5);
        chk("alu_data", bus.w_data, 64'h1234);
        drive_alu(5'd0, 64'hDEAD);
        cyc();
        chk("x0_wr", 64'(bus.reg_write), 64'd0);
        chk("x0_reg", 64'(bus.w_reg), 64'd5);
        chk("x0_data", bus.w_data, 64'h1234);
        chk("x0_cnt", 64'(bus.ld_count), 64'd0);

        // Load extension
`ifdef WB_LOAD_EXT_EN
        load_one("lb", 5'd7, 3'b000, 64'h80, 64'hFFFF_FFFF_FFFF_FF80);
        load_one("lwu", 5'd9, 3'b110, 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000);
        load_one("lh", 5'd10, 3'b001, 64'h1234_8001, 64'hFFFF_FFFF_FFFF_8001);
`else
        load_one("lb", 5'd7, 3'b000, 64'h80, 64'h80);
        load_one("lwu", 5'd9, 3'b110, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000);
        load_one("lh", 5'd10, 3'b001, 64'h1234_8001, 64'h1234_8001);
`endif

        // ALU priority while the FIFO fills, then in-order drain
        idle();
        drive_alu(5'd1, 64'h100);
        drive_ld(5'd11, 3'b011, 64'hB0B);
        cyc();
        chk("fill1_reg", 64'(bus.w_reg), 64'd1);
        chk("fill1_data", bus.w_data, 64'h100);
        chk("fill1_cnt", 64'(bus.ld_count), 64'd1);
        drive_alu(5'd1, 64'h101);
        drive_ld(5'd12, 3'b011, 64'hC0C);
        cyc();
        chk("fill2_data", bus.w_data, 64'h101);
        chk("fill2_cnt", 64'(bus.ld_count), 64'd2);
        chk("fill2_ready", 64'(bus.ld_ready), 64'd0);
        bus.ld_valid = 1'b0;
        drive_alu(5'd1, 64'h102);
        cyc();
        chk("fill3_data", bus.w_data, 64'h102);
        chk("fill3_cnt", 64'(bus.ld_count), 64'd2);
        idle();
        cyc();
        chk("drain1_reg", 64'(bus.w_reg), 64'd11);
        chk("drain1_data", bus.w_data, 64'hB0B);
        chk("drain1_cnt", 64'(bus.ld_count), 64'd1);
        chk("drain1_ready", 64'(bus.ld_ready), 64'd1);
        cyc();
        chk("drain2_reg", 64'(bus.w_reg), 64'd12);
        chk("drain2_data", bus.w_data, 64'hC0C);
        chk("drain2_cnt", 64'(bus.ld_count), 64'd0);
        cyc();
        chk("drain3_wr", 64'(bus.reg_write), 64'd0);

        // Starvation: one load behind continuous ALU traffic
        drive_alu(5'd2, 64'h200);
        drive_ld(5'd13, 3'b011, 64'hD0D);
        cyc();
        chk("starve_push_stall", 64'(bus.wb_stall), 64'd0);
        bus.ld_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            drive_alu(5'd2, 64'h200 + 64'(i));
            cyc();
        end
        chk("starve_age3_stall", 64'(bus.wb_stall), 64'd0);
        chk("starve_age3_data", bus.w_data, 64'h203);
        drive_alu(5'd2, 64'h204);
        cyc();
        chk("starve_age4_stall", 64'(bus.wb_stall), 64'd1);
        chk("starve_age4_reg", 64'(bus.w_reg), 64'd2);
        idle();
        cyc();
        chk("starve_pop_reg", 64'(bus.w_reg), 64'd13);
        chk("starve_pop_data", bus.w_data, 64'hD0D);
        chk("starve_pop_stall", 64'(bus.wb_stall), 64'd0);

        // Simultaneous push and pop at occupancy 1
        drive_ld(5'd14, 3'b011, 64'hE0E);
        cyc();
        chk("pp_push_cnt", 64'(bus.ld_count), 64'd1);
        drive_ld(5'd15, 3'b011, 64'hF0F);
        cyc();
        chk("pp_cnt", 64'(bus.ld_count), 64'd1);
        chk("pp_reg", 64'(bus.w_reg), 64'd14);
        chk("pp_data", bus.w_data, 64'hE0E);
        idle();
        cyc();
        chk("pp_tail_reg", 64'(bus.w_reg), 64'd15);
        chk("pp_tail_data", bus.w_data, 64'hF0F);
        chk("pp_tail_cnt", 64'(bus.ld_count), 64'd0);
        cyc();

        // Pointer wrap: 10 back-to-back loads with random ALU gaps
        mon_en = 1'b1;
        sent   = 0;
        budget = 0;
        while (sent < 10 && budget < 300) begin
            if (!bus.wb_stall && $urandom_range(0, 2) == 0) begin
                drive_alu(5'd31, 64'hA000 + 64'(budget));
            end else begin
                bus.alu_valid = 1'b0;
            end
            drive_ld(5'(sent + 1), 3'b011, 64'h1000 + 64'(sent));
            hs = bus.ld_ready;
            cyc();
            if (hs) sent++;
            budget++;
        end
        idle();
        repeat (6) cyc();
        mon_en = 1'b0;
        chk("wrap_sent", 64'(sent), 64'd10);
        chk("wrap_count", 64'(got_rd_q.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < got_rd_q.size()) begin
                chk($sformatf("wrap_reg%0d", i), 64'(got_rd_q[i]), 64'(i + 1));
                chk($sformatf("wrap_data%0d", i), got_data_q[i], 64'h1000 + 64'(i));
            end
        end
        chk("wrap_end_cnt", 64'(bus.ld_count), 64'd0);
        chk("wrap_end_stall", 64'(bus.wb_stall), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/wb_merge_64.md
# wb_merge_64

Writeback merge stage directly upstream of the 64-bit register file. Accepts single-cycle ALU results and variable-latency load responses, buffers loads in a small FIFO, and drives exactly one registered write port (`reg_write`, `w_reg`, `w_data`) into the register file each cycle. ALU results take priority. Loads are protected from starvation by a stall request back to the issue stage.

## Interface
- `LD_DEPTH`, 2: load FIFO entries; power of two, ≥2
- `STARVE_LIMIT`, 4: cycles a load may wait at the FIFO head before `wb_stall` asserts; ≥1

Ports:
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `alu_valid`  in  1  ALU result present this cycle; no backpressure
- `alu_rd`  in  5  ALU destination register
- `alu_data`  in  64  ALU result
- `ld_valid`  in  1  load response offered
- `ld_ready`  out  1  load response accepted when `ld_valid && ld_ready`
- `ld_rd`  in  5  load destination register
- `ld_funct3`  in  3  load type (RV64 encoding)
- `ld_data`  in  64  raw load data, right-aligned
- `wb_stall`  out  1  request to the issue stage: hold `alu_valid` low
- `ld_count`  out  $clog2(LD_DEPTH+1)  FIFO occupancy
- `reg_write`  out  1  register file write enable, registered
- `w_reg`  out  5  register file write index, registered
- `w_data`  out  64  register file write data, registered

## Operation
- **Load push:** `ld_ready = (ld_count != LD_DEPTH)`. It depends only on state, never on `ld_valid` or `alu_valid`. On a handshake, {`ld_rd`, extended data} is written at the FIFO tail.
- **Output select, each cycle, in priority order:**
  1. If `alu_valid`, register {`alu_rd`, `alu_data`}.
  2. Otherwise, if the FIFO is non-empty, pop the head and register it.
  3. Otherwise, `reg_write <= 0`.
- **x0 suppression:** a selected entry with rd == 0 is still consumed (a load entry is popped). `reg_write <= 0`, and `w_reg`/`w_data` hold their previous values.
- **When `reg_write` is 0:** `w_reg` and `w_data` always hold their previous values.
- **Push and pop in the same cycle:** allowed. Occupancy is unchanged.
- **Pop path:** a load pushed into an empty FIFO is not bypassed. It is popped no earlier than the next cycle.
- **Age counter** (width $clog2(STARVE_LIMIT+1), saturating):
  - Clears when the FIFO is empty or a pop occurs.
  - Otherwise increments by 1 per cycle.
  - `wb_stall = (age >= STARVE_LIMIT)`, decoded from state only.
  - `wb_stall` falls the cycle after the head is popped.
- **`alu_valid` while `wb_stall` is high:** a protocol violation. The ALU still wins and the age counter keeps saturating. A simulation assertion flags it.
- **Load extension by `ld_funct3`** (see Configuration):

  | `ld_funct3` | Load | Extension |
  |---|---|---|
  | 000 | LB | sign-extend [7:0] |
  | 001 | LH | sign-extend [15:0] |
  | 010 | LW | sign-extend [31:0] |
  | 011 | LD | full 64 bits |
  | 100 | LBU | zero-extend [7:0] |
  | 101 | LHU | zero-extend [15:0] |
  | 110 | LWU | zero-extend [31:0] |
  | 111 | (reserved) | treated as LD |

## Timing
- **Reset** (async assert, synchronous deassert upstream):
  - `reg_write`, `w_reg`, `w_data`, `ld_count`, `wb_stall` = 0; FIFO pointers and age counter = 0.
  - `ld_ready` = 1.
- **ALU latency:** result on `w_*` 1 cycle after `alu_valid`.
- **Load latency:** minimum 2 cycles from handshake to `w_*` (push at edge N, pop at edge N+1).
- **Throughput:** one write per cycle. A full FIFO with no ALU traffic drains at 1 entry per cycle.
- **Reset mid-operation:** FIFO contents are discarded. In-flight loads are lost, and the upstream owner must reissue them.

## Configuration
- `WB_LOAD_EXT_EN` defined: `ld_funct3` extension is applied at push time as in the Operation table.
- `WB_LOAD_EXT_EN` undefined:
  - `ld_funct3` is ignored and `ld_data` is stored unmodified (the memory side is responsible for extension).
  - The extension logic is absent.

## Test plan
- **Reset, ALU write, x0 drop:** assert `reset_n` = 0 mid-stream -> all outputs 0 and `ld_ready` = 1. Then drive `alu_valid`, rd = 5, data = 0x1234 -> next cycle `reg_write` = 1, `w_reg` = 5, `w_data` = 0x1234. Then drive rd = 0 -> `reg_write` = 0, `w_reg`/`w_data` unchanged.
- **Load extension, both builds:** load rd = 7, funct3 = 000, data = 0x80 -> 2 cycles later `w_data` = 0xFFFF_FFFF_FFFF_FF80. With funct3 = 110, data = 0xFFFF_FFFF_8000_0000 -> `w_data` = 0x0000_0000_8000_0000. With the macro undefined -> raw data passes through.
- **Priority and FIFO fill:** push 2 loads while `alu_valid` is held high -> `ld_count` = 2, `ld_ready` = 0, only ALU writes appear. Drop `alu_valid` -> loads written in FIFO order on consecutive cycles, `ld_count` 2 -> 1 -> 0.
- **Starvation:** with `STARVE_LIMIT` = 4, keep a load queued behind continuous ALU traffic -> `wb_stall` = 1 after 4 cycles of waiting. Release `alu_valid` -> load written, `wb_stall` = 0 the cycle after.
- **Simultaneous push and pop:** with `ld_count` = 1 and no ALU, push a load -> `ld_count` stays 1, head written, order preserved.
- **Pointer wrap:** stream 10 back-to-back loads with random ALU gaps -> every load written exactly once, in order, with no duplicates and no loss.
